// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types, operator codes and key map for the keypad scanner
package calc_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_EMIT,
        ST_WAIT_RELEASE
    } state_e;

    localparam int SCAN_CYCLES_DEF     = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 16;

    localparam logic [3:0] OP_ADD    = 4'hA;
    localparam logic [3:0] OP_SUB    = 4'hB;
    localparam logic [3:0] OP_MUL    = 4'hC;
    localparam logic [3:0] OP_DIV    = 4'hD;
    localparam logic [3:0] OP_CLEAR  = 4'hE;
    localparam logic [3:0] OP_EQUALS = 4'hF;

    // Nibble at index row*4+col; row 0 occupies the low 16 bits.
    localparam logic [63:0] KEY_TABLE = 64'hDF0E_C987_B654_A321;

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEY_TABLE[{row, col, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/keypad_key_map.sv
// rtl/keypad_key_map.sv - combinational (row, col) to key code, digit one-hot and operator flag
module keypad_key_map
    import calc_pkg::*;
(
    input  logic [1:0] row_i,
    input  logic [1:0] col_i,
    output logic [3:0] key_code_o,
    output logic [9:0] digit_o,
    output logic       is_op_o
);

    always_comb begin
        key_code_o = key_lookup(row_i, col_i);
        is_op_o    = (key_code_o >= OP_ADD);
        digit_o    = '0;
        if (!is_op_o) begin
            digit_o[key_code_o] = 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with press/release debounce
// and registered one-cycle key, digit and operator pulses.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_CYCLES     = SCAN_CYCLES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       zero,
    output logic       one,
    output logic       two,
    output logic       three,
    output logic       four,
    output logic       five,
    output logic       six,
    output logic       seven,
    output logic       eight,
    output logic       nine,
    output logic       op_valid,
    output logic [3:0] op_code,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    state_e        state_q;
    logic [1:0]    col_q, col_d;
    logic [1:0]    row_q;
    logic [1:0]    low_row;
    logic [DW-1:0] dwell_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    col_out_q;
    logic          key_valid_q, op_valid_q;
    logic [3:0]    key_code_q, op_code_q;
    logic [9:0]    digit_q;

    logic [3:0]    map_code;
    logic [9:0]    map_digit;
    logic          map_is_op;
    logic          sample_last, rows_idle, row_held;

    keypad_key_map u_key_map (
        .row_i      (row_q),
        .col_i      (col_q),
        .key_code_o (map_code),
        .digit_o    (map_digit),
        .is_op_o    (map_is_op)
    );

    // Lowest-index low row wins when several keys share the column.
    always_comb begin
        low_row = 2'd3;
        for (int r = 3; r >= 0; r--) begin
            if (!row_in[r]) low_row = 2'(r);
        end
    end

    assign sample_last = (dwell_q == DWELL_LAST);
    assign rows_idle   = (row_in == 4'hF);
    assign row_held    = !row_in[row_q];

    always_comb begin
        col_d = col_q;
        if (state_q == ST_SCAN && sample_last && rows_idle) begin
            col_d = col_q + 2'd1;
        end
        if (state_q == ST_WAIT_RELEASE && rows_idle && cnt_q == DEB_LAST) begin
            col_d = col_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_SCAN;
            col_q       <= 2'd0;
            row_q       <= 2'd0;
            dwell_q     <= '0;
            cnt_q       <= '0;
            col_out_q   <= 4'b1110;
            key_valid_q <= 1'b0;
            op_valid_q  <= 1'b0;
            key_code_q  <= 4'h0;
            op_code_q   <= 4'h0;
            digit_q     <= '0;
        end else begin
            col_q       <= col_d;
            col_out_q   <= ~(4'b0001 << col_d);
            key_valid_q <= 1'b0;
            op_valid_q  <= 1'b0;
            digit_q     <= '0;
            case (state_q)
                ST_SCAN: begin
                    if (sample_last) begin
                        dwell_q <= '0;
                        if (!rows_idle) begin
                            row_q   <= low_row;
                            cnt_q   <= '0;
                            state_q <= ST_DEBOUNCE;
                        end
                    end else begin
                        dwell_q <= dwell_q + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!row_held) begin
                        state_q <= ST_SCAN;
                        dwell_q <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        // Outputs load on the same edge the FSM enters EMIT.
                        cnt_q       <= cnt_q + 1'b1;
                        state_q     <= ST_EMIT;
                        key_valid_q <= 1'b1;
                        key_code_q  <= map_code;
                        digit_q     <= map_digit;
                        op_valid_q  <= map_is_op;
                        if (map_is_op) op_code_q <= map_code;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_EMIT: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT_RELEASE;
                end
                ST_WAIT_RELEASE: begin
                    if (!rows_idle) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        cnt_q   <= '0;
                        dwell_q <= '0;
                        state_q <= ST_SCAN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_SCAN;
            endcase
        end
    end

    assign col_out   = col_out_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign op_valid  = op_valid_q;
    assign op_code   = op_code_q;
    assign zero      = digit_q[0];
    assign one       = digit_q[1];
    assign two       = digit_q[2];
    assign three     = digit_q[3];
    assign four      = digit_q[4];
    assign five      = digit_q[5];
    assign six       = digit_q[6];
    assign seven     = digit_q[7];
    assign eight     = digit_q[8];
    assign nine      = digit_q[9];

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - keypad scanner bench: virtual keypad, expected-key queue, per-cycle compare
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_in, col_out, op_code, key_code;
    logic       zero, one, two, three, four, five, six, seven, eight, nine;
    logic       op_valid, key_valid;
    logic [9:0] digits;
    logic [15:0] held = '0;
    int errors = 0;
    int checks = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_CYCLES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out),
        .zero(zero), .one(one), .two(two), .three(three), .four(four),
        .five(five), .six(six), .seven(seven), .eight(eight), .nine(nine),
        .op_valid(op_valid), .op_code(op_code), .key_valid(key_valid), .key_code(key_code)
    );

    assign digits = {nine, eight, seven, six, five, four, three, two, one, zero};

    // Virtual keypad: a held key pulls its row low while its column is driven.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col_out[c] && held[r*4+c]) row_in[r] = 1'b0;
    end

    function automatic int key_of(int r, int c);
        if (c == 3) return 10 + r;
        if (r < 3) return r * 3 + c + 1;
        case (c)
            0:       return 14;
            1:       return 0;
            default: return 15;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_key(int r, int c, logic v);
        held[r*4+c] = v;
    endtask

    task automatic idle(int cycles);
        held = '0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic wait_drain(int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_key(int max_cycles, output int n);
        n = 0;
        while (!key_valid && n < max_cycles) begin
            @(posedge clk);
            #2;
            n++;
        end
    endtask

    // Per-cycle compare against the expected-key queue.
    always begin
        int k;
        @(posedge clk);
        #1;
        check("col_one_low", $countones(~col_out), 1);
        if (!key_valid) begin
            check("idle_pulses", {21'd0, op_valid, digits}, 32'd0);
        end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_key: got %0h expected none at %0t", key_code, $time);
        end else begin
            k = exp_q.pop_front();
            check("key_code", key_code, k);
            check("digits", digits, (k < 10) ? (32'd1 << k) : 32'd0);
            check("op_valid", op_valid, (k >= 10) ? 1 : 0);
            if (k >= 10) check("op_code", op_code, k);
        end
    end

    initial begin
        int n;
        int w;
        repeat (3) @(posedge clk);
        #1;
        check("rst_col_out", col_out, 4'b1110);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_code", key_code, 0);
        check("rst_op_code", op_code, 0);
        check("rst_op_valid", op_valid, 0);

        // '5' held from reset release: sample on 4th edge, emit on 8th.
        @(negedge clk);
        set_key(1, 1, 1'b1);
        exp_q.push_back(key_of(1, 1));
        rst_n = 1'b1;
        wait_key(40, n);
        check("lat_5", n, 8);
        check("lit_code_5", key_code, 4'h5);
        check("lit_five", five, 1);
        repeat (100) @(negedge clk);
        check("no_repeat_5", exp_q.size(), 0);
        idle(20);

        // Bounce on row1 while column 1 is driven: no emission until stable.
        w = 0;
        while (col_out !== 4'b1110 && w < 50) begin @(negedge clk); w++; end
        while (col_out !== 4'b1101 && w < 50) begin @(negedge clk); w++; end
        check("bounce_col_wait", (w < 50) ? 1 : 0, 1);
        set_key(1, 1, 1'b1);
        repeat (2) @(negedge clk);
        set_key(1, 1, 1'b0);
        @(negedge clk);
        exp_q.push_back(key_of(1, 1));
        set_key(1, 1, 1'b1);
        wait_drain(60);
        idle(20);

        // Short release does not re-arm; long release does.
        exp_q.push_back(key_of(1, 1));
        set_key(1, 1, 1'b1);
        wait_drain(60);
        repeat (5) @(negedge clk);
        set_key(1, 1, 1'b0);
        repeat (2) @(negedge clk);
        set_key(1, 1, 1'b1);
        repeat (30) @(negedge clk);
        set_key(1, 1, 1'b0);
        repeat (6) @(negedge clk);
        exp_q.push_back(key_of(1, 1));
        set_key(1, 1, 1'b1);
        wait_drain(60);
        idle(20);

        // '2' and '8' share column 1: row priority picks '2'.
        exp_q.push_back(key_of(0, 1));
        set_key(0, 1, 1'b1);
        set_key(2, 1, 1'b1);
        wait_drain(60);
        repeat (20) @(negedge clk);
        idle(20);

        // Reset during debounce of '7' discards it; rescanning finds it again.
        rst_n = 1'b0;
        set_key(2, 0, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        check("mid_rst_col_out", col_out, 4'b1110);
        check("mid_rst_seven", seven, 0);
        @(negedge clk);
        exp_q.push_back(key_of(2, 0));
        rst_n = 1'b1;
        wait_key(40, n);
        check("lat_7", n, 6);
        check("lit_code_7", key_code, 4'h7);
        repeat (10) @(negedge clk);
        idle(20);

        // '=' operator key.
        exp_q.push_back(key_of(3, 2));
        set_key(3, 2, 1'b1);
        wait_key(60, n);
        check("eq_key_valid", key_valid, 1);
        check("lit_op_code_eq", op_code, 4'hF);
        check("lit_key_code_eq", key_code, 4'hF);
        check("lit_op_valid_eq", op_valid, 1);
        check("lit_digits_eq", digits, 0);
        repeat (20) @(negedge clk);
        idle(20);

        check("final_queue", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_CYCLES, default 4: number of clock cycles each column is driven before its rows are sampled.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive stable cycles required for both press and release.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 row_in  in  4  keypad rows, active-low, pre-synchronised externally.
REQ-006 col_out  out  4  column drive, active-low, exactly one bit low at all times.
REQ-007 zero..nine  out  1 each  one-cycle digit pulses, directly feeding the digit-to-binary stage.
REQ-008 op_valid  out  1  one-cycle pulse for an operator key.
REQ-009 op_code  out  4  operator code: A=+, B=-, C=*, D=/, E=clear, F=equals; valid only with op_valid.
REQ-010 key_valid  out  1  one-cycle pulse on every accepted key.
REQ-011 key_code  out  4  key value (0-9 or A-F); valid only with key_valid.

Function
REQ-012 Key map by (row, col): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = E 0 F D.
REQ-013 FSM states: SCAN, DEBOUNCE, EMIT, WAIT_RELEASE.
REQ-014 SCAN: col_out = ~(1<<col_idx); dwell counter runs to SCAN_CYCLES-1, and rows are sampled on that last dwell cycle.
REQ-015 SCAN sample with row_in all high: col_idx increments mod 4 (3 wraps to 0) and the dwell counter clears.
REQ-016 SCAN sample with any row low: latch col_idx, latch lowest-index low row (priority), clear the debounce counter, go to DEBOUNCE.
REQ-017 DEBOUNCE: column held; each cycle in which the latched row is still low increments the counter.
REQ-018 DEBOUNCE exit on success: at count DEBOUNCE_CYCLES, go to EMIT.
REQ-019 DEBOUNCE exit on failure: if the latched row reads high, go to SCAN on the same column with the dwell counter cleared and no output.
REQ-020 EMIT lasts exactly one cycle, with registered outputs: key_valid=1, key_code=map, plus the matching digit line or op_valid/op_code; then go to WAIT_RELEASE.
REQ-021 Latency: with stable rows, key_valid is high in cycle T+DEBOUNCE_CYCLES+1, where T is the sampling cycle.
REQ-022 WAIT_RELEASE: column held; counter increments while row_in==4'hF and clears on any low row.
REQ-023 WAIT_RELEASE exit: at DEBOUNCE_CYCLES, go to SCAN with col_idx+1 mod 4.
REQ-024 Held keys never repeat.
REQ-025 Keys pressed in other columns during DEBOUNCE/WAIT_RELEASE are ignored; they are detected on later scans if still held.
REQ-026 At most one of zero..nine/op_valid is high in any cycle, and never outside EMIT.
REQ-027 All outputs are registered; no combinational path from row_in to any output.
REQ-028 Counter widths are sized with $clog2 of the parameters; no counter wraps.

Reset
REQ-029 With rst_n=0 at a clock edge: state=SCAN, col_idx=0, col_out=4'b1110, all counters=0.
REQ-030 Output values after that reset edge: all pulses=0, key_code=0, op_code=0.
REQ-031 Reset mid-DEBOUNCE or mid-EMIT discards the key with no pulse; scanning restarts at column 0 on the first cycle after release of rst_n.

Structure
REQ-032 Shared package calc_pkg holds: FSM state encoding, operator code constants (A-F), key map table, default parameter values.
REQ-033 One combinational sub-module keypad_key_map: maps (row, col) to key_code, digit one-hot and operator flag; the FSM instantiates it once.

Verification (SCAN_CYCLES=2, DEBOUNCE_CYCLES=4)
REQ-034 Press '5' stable for 100 cycles -> exactly one pulse on five, key_code=4'h5, key_valid 1 cycle, no other outputs, no repeat.
REQ-035 Bounce on row1 (low 2 cycles, high 1 cycle, then stable low) -> no emission during the bounce, then exactly one five pulse after stabilisation.
REQ-036 Press '5', release for 2 cycles, press again -> single pulse; release for 6 cycles, press again -> second pulse.
REQ-037 '2' and '8' held together (col1, rows 0 and 2) -> one pulse on two only, key_code=4'h2.
REQ-038 rst_n=0 during DEBOUNCE of '7' -> no seven pulse, col_out=4'b1110 after the edge, scanning resumes and '7' is detected if still held.
REQ-039 Press '=' (r3, c2) -> op_valid 1 cycle, op_code=4'hF, key_code=4'hF, no digit pulses.
